gg_bit_packer: RTL and testbench

// Receiving end of the gg_process CAVLC output (bits/bitcount per 4x4 block).
// - Takes one variable-length block codeword per handshake, MSB-first.
// - Concatenates codewords and emits packed 32-bit big-endian words for the slice NAL writer.
// - On flush, appends the rbsp stop bit and zero-pads to a byte boundary.

---
 rtl/gg_bit_packer.sv | 174 +++++++++++++++++
 tb/tb_gg_bit_packer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gg_bit_packer.sv
// CAVLC block bit packer: concatenates MSB-first block codewords into 32-bit big-endian words,
// appending the rbsp stop bit and byte padding when a unit is flushed.
module gg_bit_packer #(
  parameter int unsigned BLK_W = 512,
  parameter int unsigned CNT_W = 9,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TOT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_bits,
  input  logic [CNT_W-1:0] in_bitcount,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [2:0]       out_nbytes,
  output logic [TOT_W-1:0] bits_total,
  output logic             busy
);

  localparam int unsigned ACC_W  = 2 * OUT_W;
  localparam int unsigned FILL_W = $clog2(ACC_W + 1);
  localparam int unsigned SH_W   = $clog2(BLK_W) + 1;

  localparam logic [FILL_W-1:0] FILL_WORD = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(ACC_W);
  localparam logic [CNT_W-1:0]  REM_WORD  = CNT_W'(OUT_W);
  localparam logic [ACC_W-1:0]  ACC_MSB   = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, LAST} state_t;

  state_t            state, state_nx;
  logic [BLK_W-1:0]  blk, blk_nx;
  logic [CNT_W-1:0]  rem, rem_nx;
  logic              flush_q, flush_nx;
  logic [ACC_W-1:0]  acc, acc_nx;
  logic [FILL_W-1:0] fill, fill_nx;
  logic              in_ready_nx, busy_nx;
  logic              out_valid_nx, out_last_nx;
  logic [OUT_W-1:0]  out_data_nx;
  logic [2:0]        out_nbytes_nx;
  logic [TOT_W-1:0]  bits_total_nx;

  // scratch values for the drain-then-refill ordering within one cycle
  logic              out_free;
  logic [ACC_W-1:0]  acc_a;
  logic [FILL_W-1:0] fill_a;
  logic [CNT_W-1:0]  k;
  logic [CNT_W-1:0]  rem_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      blk        <= '0;
      rem        <= '0;
      flush_q    <= 1'b0;
      acc        <= '0;
      fill       <= '0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_nbytes <= '0;
      bits_total <= '0;
    end else begin
      state      <= state_nx;
      blk        <= blk_nx;
      rem        <= rem_nx;
      flush_q    <= flush_nx;
      acc        <= acc_nx;
      fill       <= fill_nx;
      in_ready   <= in_ready_nx;
      busy       <= busy_nx;
      out_valid  <= out_valid_nx;
      out_data   <= out_data_nx;
      out_last   <= out_last_nx;
      out_nbytes <= out_nbytes_nx;
      bits_total <= bits_total_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    blk_nx        = blk;
    rem_nx        = rem;
    flush_nx      = flush_q;
    acc_nx        = acc;
    fill_nx       = fill;
    out_valid_nx  = out_valid;
    out_data_nx   = out_data;
    out_last_nx   = out_last;
    out_nbytes_nx = out_nbytes;
    bits_total_nx = bits_total;
    out_free      = !out_valid || out_ready;
    acc_a         = acc;
    fill_a        = fill;
    k             = '0;
    rem_v         = rem;

    if (out_valid && out_ready) begin
      out_valid_nx = 1'b0;
    end

    // Output register: full words in any state, the tail word only while closing a unit
    if (out_free && (fill >= FILL_WORD || (state == LAST && fill != '0))) begin
      out_valid_nx = 1'b1;
      out_data_nx  = acc[ACC_W-1 -: OUT_W];
      if (state == LAST && fill <= FILL_WORD) begin
        out_last_nx   = 1'b1;
        out_nbytes_nx = 3'(fill >> 3);
        acc_a         = '0;
        fill_a        = '0;
      end else begin
        out_last_nx   = 1'b0;
        out_nbytes_nx = 3'd4;
        acc_a         = acc << OUT_W;
        fill_a        = fill - FILL_WORD;
      end
    end
    acc_nx  = acc_a;
    fill_nx = fill_a;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          // left-align the codeword; bits above in_bitcount fall off the top
          blk_nx        = in_bits << (SH_W'(BLK_W) - SH_W'(in_bitcount));
          rem_nx        = in_bitcount;
          flush_nx      = in_flush;
          bits_total_nx = bits_total + TOT_W'(in_bitcount);
          state_nx      = LOAD;
        end
      end
      LOAD: begin
        if (rem != '0 && fill <= FILL_WORD) begin
          k       = (rem > REM_WORD) ? REM_WORD : rem;
          acc_nx  = acc_a | ({blk[BLK_W-1 -: OUT_W], {OUT_W{1'b0}}} >> fill_a);
          fill_nx = fill_a + FILL_W'(k);
          rem_v   = rem - k;
          rem_nx  = rem_v;
          blk_nx  = blk << OUT_W;
        end
        if (rem_v == '0) begin
          state_nx = flush_q ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        // a completely full, stalled accumulator must drain one word before the stop bit fits
        if (fill_a < FILL_FULL) begin
          acc_nx   = acc_a | (ACC_MSB >> fill_a);
          fill_nx  = (fill_a + FILL_W'(8)) & ~FILL_W'(7);
          state_nx = LAST;
        end
      end
      LAST: begin
        if (out_valid && out_ready && out_last) begin
          bits_total_nx = '0;
          flush_nx      = 1'b0;
          state_nx      = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    in_ready_nx = (state_nx == IDLE);
    busy_nx     = (state_nx != IDLE) || (fill_nx != '0) || out_valid_nx;
  end

endmodule

// File: tb/tb_gg_bit_packer.sv
// Directed bench for gg_bit_packer: hand-computed words, latency, flush tail and backpressure.
module tb_gg_bit_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_bits;
  logic [8:0]   in_bitcount;
  logic         in_flush;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [2:0]   out_nbytes;
  logic [31:0]  bits_total;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [35:0] words[$];   // {last, nbytes, data}
  logic        hold;
  logic [36:0] held_v;

  gg_bit_packer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .in_bitcount(in_bitcount), .in_flush(in_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_nbytes(out_nbytes),
    .bits_total(bits_total), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // present a block and hold it until the accepting edge
  task automatic send(input logic [511:0] bits, input logic [8:0] cnt, input logic fl);
    int t = 0;
    in_bits = bits; in_bitcount = cnt; in_flush = fl; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    check("send_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int t = 0;
    while (words.size() < n && t < budget) begin
      tick();
      t++;
    end
    check("word_count", 64'(words.size()), 64'(n));
  endtask

  task automatic pop_check(input string tag, input logic [31:0] d, input logic l, input logic [2:0] nb);
    logic [35:0] w;
    w = 'x;
    if (words.size() != 0) w = words.pop_front();
    check(tag, 64'(w), 64'({l, nb, d}));
  endtask

  // transfer capture and stall-stability monitor
  always @(negedge clk) begin
    if (reset) begin
      hold <= 1'b0;
    end else begin
      if (hold) check("stall_hold", 64'({out_valid, out_last, out_nbytes, out_data}), 64'(held_v));
      if (out_valid && out_ready) words.push_back({out_last, out_nbytes, out_data});
      hold   <= out_valid && !out_ready;
      held_v <= {1'b1, out_last, out_nbytes, out_data};
    end
  end

  initial begin
    logic [511:0] b;
    int vcnt;
    reset = 1'b1; in_valid = 1'b0; in_bits = '0; in_bitcount = '0; in_flush = 1'b0;
    out_ready = 1'b1; hold = 1'b0; held_v = '0;

    // 1. reset state, then reset in the middle of a long block
    tick(2);
    reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_bits_total", 64'(bits_total), 64'd0);
    out_ready = 1'b0;
    send({512{1'b1}}, 9'd511, 1'b0);
    tick(3);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    words.delete();
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_busy", 64'(busy), 64'd0);
    check("rst2_bits_total", 64'(bits_total), 64'd0);
    out_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) vcnt++;
      tick();
    end
    check("rst2_no_word", 64'(vcnt + words.size()), 64'd0);

    // 2. one full word, two-cycle latency
    send(512'hDEADBEEF, 9'd32, 1'b0);
    check("t2_total", 64'(bits_total), 64'd32);
    tick();
    check("t2_not_yet", 64'(out_valid), 64'd0);
    tick();
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_data", 64'(out_data), 64'hDEADBEEF);
    check("t2_last", 64'(out_last), 64'd0);
    check("t2_nbytes", 64'(out_nbytes), 64'd4);
    wait_words(1, 10);
    pop_check("t2_word", 32'hDEADBEEF, 1'b0, 3'd4);

    // 3. short flushed block; garbage above the bitcount must be ignored
    b = {512{1'b1}};
    b[4:0] = 5'b10110;
    send(b, 9'd5, 1'b1);
    check("t3_total", 64'(bits_total), 64'd37);
    wait_words(1, 20);
    pop_check("t3_word", 32'hB4000000, 1'b1, 3'd1);
    tick(2);
    check("t3_total_clr", 64'(bits_total), 64'd0);
    check("t3_idle", 64'({in_ready, busy}), 64'b10);

    // 4. full word with flush, then empty flush
    send(512'hDEADBEEF, 9'd32, 1'b1);
    wait_words(2, 20);
    pop_check("t4_w0", 32'hDEADBEEF, 1'b0, 3'd4);
    pop_check("t4_w1", 32'h80000000, 1'b1, 3'd1);
    tick(2);
    check("t4_total_clr", 64'(bits_total), 64'd0);
    send(512'h0, 9'd0, 1'b1);
    wait_words(1, 20);
    pop_check("t4_stop", 32'h80000000, 1'b1, 3'd1);

    // 5. 511 ones under alternating backpressure, then flush the 31-bit tail
    tick(2);
    send({512{1'b1}}, 9'd511, 1'b0);
    check("t5_total", 64'(bits_total), 64'd511);
    for (int i = 0; i < 100; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    tick(2);
    check("t5_count", 64'(words.size()), 64'd15);
    for (int i = 0; i < 15; i++) pop_check("t5_word", 32'hFFFFFFFF, 1'b0, 3'd4);
    check("t5_pending", 64'({in_ready, busy}), 64'b11);
    send(512'h0, 9'd0, 1'b1);
    check("t5_total_keep", 64'(bits_total), 64'd511);
    wait_words(1, 20);
    pop_check("t5_tail", 32'hFFFFFFFF, 1'b1, 3'd4);
    tick(2);
    check("t5_total_clr", 64'(bits_total), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);

    // 6. three 12-bit blocks straddling a word boundary
    send(512'hABC, 9'd12, 1'b0);
    send(512'h123, 9'd12, 1'b0);
    send(512'h456, 9'd12, 1'b1);
    check("t6_total", 64'(bits_total), 64'd36);
    wait_words(2, 20);
    pop_check("t6_w0", 32'hABC12345, 1'b0, 3'd4);
    pop_check("t6_w1", 32'h68000000, 1'b1, 3'd1);
    tick(3);
    check("t6_extra", 64'(words.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
